backup_row_scheduler: RTL

BACKUP_ROW_SCHEDULER -- requirements
Module: backup_row_scheduler

---
 rtl/backup_row_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/backup_row_scheduler.sv
// Backup-row scheduler: streams cfg_k backup-row transfers per tile and walks the
// feature row in tiles of CGS (or 2*CGS in stride-2) columns, with a handshake per tile.
module backup_row_scheduler #(
    parameter int MAX_K = 7,
    parameter int CGS   = 16,
    parameter int WW    = 12,
    parameter int PW    = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(MAX_K+1)-1:0]   cfg_k,
    input  logic [WW-1:0]                cfg_rowWidth,
    input  logic [PW-1:0]                cfg_leftPad,
    input  logic                         cfg_s2,
    input  logic                         fifo_empty,
    input  logic                         tile_ack,
    output logic                         sendBackUpInput_valid,
    output logic [$clog2(MAX_K)-1:0]     backupId,
    output logic [WW-1:0]                readWidth,
    output logic [PW-1:0]                leftPad,
    output logic                         isStride2,
    output logic                         tile_ready,
    output logic                         busy,
    output logic                         done
);
    localparam int KW = $clog2(MAX_K + 1);
    localparam int IW = $clog2(MAX_K);
    localparam logic [WW:0] SPAN1 = (WW+1)'(CGS);
    localparam logic [WW:0] SPAN2 = (WW+1)'(2 * CGS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, FINISH} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  row_q, row_d;
    logic [WW-1:0]  tile_q, tile_d;
    logic [WW:0]    num_tiles_q, num_tiles_d;
    logic [WW-1:0]  rem_q, rem_d;
    logic [KW-1:0]  k_q, k_d;
    logic           s2_q, s2_d;
    logic [WW-1:0]  read_width_q, read_width_d;
    logic [PW-1:0]  left_pad_q, left_pad_d;
    logic           valid_q, valid_d;
    logic           tile_ready_q, tile_ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [WW:0]    span_cfg, total_cfg, tiles_cfg, first_room, span_q;
    logic [WW-1:0]  first_rd, rem_after, next_rd;
    logic           part_cfg;
    logic [KW-1:0]  row_ext;

    // Tile sizing for the layer being captured, and for the tile after the current one.
    always_comb begin
        span_cfg  = cfg_s2 ? SPAN2 : SPAN1;
        total_cfg = {1'b0, cfg_rowWidth} + (WW+1)'(cfg_leftPad);
        if (cfg_s2) begin
            tiles_cfg = total_cfg / SPAN2;
            part_cfg  = |(total_cfg % SPAN2);
        end else begin
            tiles_cfg = total_cfg / SPAN1;
            part_cfg  = |(total_cfg % SPAN1);
        end
        tiles_cfg  = tiles_cfg + (WW+1)'(part_cfg);
        first_room = span_cfg - (WW+1)'(cfg_leftPad);
        first_rd   = ({1'b0, cfg_rowWidth} < first_room) ? cfg_rowWidth : first_room[WW-1:0];

        span_q    = s2_q ? SPAN2 : SPAN1;
        rem_after = rem_q - read_width_q;
        next_rd   = ({1'b0, rem_after} < span_q) ? rem_after : span_q[WW-1:0];
        row_ext   = KW'(row_q);
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        tile_d       = tile_q;
        num_tiles_d  = num_tiles_q;
        rem_d        = rem_q;
        k_d          = k_q;
        s2_d         = s2_q;
        read_width_d = read_width_q;
        left_pad_d   = left_pad_q;
        valid_d      = valid_q;
        tile_ready_d = tile_ready_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = ISSUE;
                    row_d        = '0;
                    tile_d       = '0;
                    k_d          = cfg_k;
                    s2_d         = cfg_s2;
                    num_tiles_d  = tiles_cfg;
                    rem_d        = cfg_rowWidth;
                    read_width_d = first_rd;
                    left_pad_d   = cfg_leftPad;
                    valid_d      = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            ISSUE: begin
                // An empty FIFO stalls everything; the request stays asserted.
                if (!fifo_empty) begin
                    if (row_ext == k_q - KW'(1)) begin
                        state_d      = WAIT_ACK;
                        row_d        = '0;
                        valid_d      = 1'b0;
                        tile_ready_d = 1'b1;
                    end else begin
                        row_d = row_q + IW'(1);
                    end
                end
            end
            WAIT_ACK: begin
                if (tile_ack) begin
                    tile_ready_d = 1'b0;
                    if ({1'b0, tile_q} == num_tiles_q - (WW+1)'(1)) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = ISSUE;
                        tile_d       = tile_q + WW'(1);
                        rem_d        = rem_after;
                        read_width_d = next_rd;
                        left_pad_d   = '0;
                        valid_d      = 1'b1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            row_q        <= '0;
            tile_q       <= '0;
            num_tiles_q  <= '0;
            rem_q        <= '0;
            k_q          <= '0;
            s2_q         <= 1'b0;
            read_width_q <= '0;
            left_pad_q   <= '0;
            valid_q      <= 1'b0;
            tile_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            tile_q       <= tile_d;
            num_tiles_q  <= num_tiles_d;
            rem_q        <= rem_d;
            k_q          <= k_d;
            s2_q         <= s2_d;
            read_width_q <= read_width_d;
            left_pad_q   <= left_pad_d;
            valid_q      <= valid_d;
            tile_ready_q <= tile_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign sendBackUpInput_valid = valid_q;
    assign backupId              = row_q;
    assign readWidth             = read_width_q;
    assign leftPad               = left_pad_q;
    assign isStride2             = s2_q;
    assign tile_ready            = tile_ready_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
endmodule
